// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: handshake and bus signals between the ALU, the result stage and the write-back consumer
// slave modport: the result stage (takes *_IN, drives *_OUT); master modport: the surrounding datapath
interface alu_result_stage_if;
  logic [7:0] alu_result_IN;
  logic       negative_FLAG_IN;
  logic       overflow_FLAG_IN;
  logic       zero_FLAG_IN;
  logic       carry_FLAG_IN;
  logic [7:0] a_REG_IN;
  logic [7:0] b_REG_IN;
  logic       sum_op_IN;
  logic       subtract_IN;
  logic [3:0] flag_MASK_IN;
  logic       result_VALID_IN;
  logic       result_READY_OUT;
  logic [7:0] hold_REG_OUT;
  logic       hold_VALID_OUT;
  logic       hold_READY_IN;
  logic       p_LOAD_IN;
  logic [7:0] p_DATA_IN;
  logic [7:0] flag_SET_IN;
  logic [7:0] flag_CLR_IN;
  logic [7:0] p_REG_OUT;
  modport slave (
    input  alu_result_IN, negative_FLAG_IN, overflow_FLAG_IN, zero_FLAG_IN, carry_FLAG_IN,
           a_REG_IN, b_REG_IN, sum_op_IN, subtract_IN, flag_MASK_IN, result_VALID_IN,
           hold_READY_IN, p_LOAD_IN, p_DATA_IN, flag_SET_IN, flag_CLR_IN,
    output result_READY_OUT, hold_REG_OUT, hold_VALID_OUT, p_REG_OUT
  );
  modport master (
    output alu_result_IN, negative_FLAG_IN, overflow_FLAG_IN, zero_FLAG_IN, carry_FLAG_IN,
           a_REG_IN, b_REG_IN, sum_op_IN, subtract_IN, flag_MASK_IN, result_VALID_IN,
           hold_READY_IN, p_LOAD_IN, p_DATA_IN, flag_SET_IN, flag_CLR_IN,
    input  result_READY_OUT, hold_REG_OUT, hold_VALID_OUT, p_REG_OUT
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: one-entry ALU result hold buffer plus the 6502 status register P
// Ports: clk, reset_N (async active-low), bus (alu_result_stage_if.slave: result handshake in,
// hold handshake out, P load/set/clear strobes, p_REG_OUT). Optional macro DECIMAL_MODE_EN adds
// the NMOS BCD correction cycle (DECADJ) for ADC/SBC when P.D=1.
module alu_result_stage #(
  parameter logic [7:0] P_RESET_VALUE    = 8'h24,
  parameter logic [7:0] HOLD_RESET_VALUE = 8'h00
) (
  input logic clk,
  input logic reset_N,
  alu_result_stage_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY,
    FULL
`ifdef DECIMAL_MODE_EN
    , DECADJ
`endif
  } state_t;
  state_t state;
  logic [7:0] hold, p, p_alu, p_next;
  logic valid, capture;
  assign bus.result_READY_OUT = reset_N & (state == EMPTY | (state == FULL & bus.hold_READY_IN));
  assign capture = bus.result_VALID_IN & bus.result_READY_OUT;
  assign bus.hold_REG_OUT = hold;
  assign bus.hold_VALID_OUT = valid;
  assign bus.p_REG_OUT = p;
`ifdef DECIMAL_MODE_EN
  logic [7:0] da, db, dec_res;
  logic dcin, dsub, dmask_c, dec_go, c_lo, dec_c;
  logic [5:0] lo, lo_adj, hi, hi_adj;
  assign dec_go = bus.sum_op_IN & p[3];
  // ADC adds 6 per nibble when it exceeds 9; SBC (b pre-inverted) subtracts 6 when a nibble borrows
  always_comb begin
    lo = {2'b0, da[3:0]} + {2'b0, db[3:0]} + {5'b0, dcin};
    lo_adj = dsub ? (lo[4] ? lo : lo - 6'd6) : (lo > 6'd9 ? lo + 6'd6 : lo);
    c_lo = dsub ? lo[4] : lo_adj > 6'd15;
    hi = {2'b0, da[7:4]} + {2'b0, db[7:4]} + {5'b0, c_lo};
    hi_adj = dsub ? (hi[4] ? hi : hi - 6'd6) : (hi > 6'd9 ? hi + 6'd6 : hi);
    dec_c = dsub ? hi[4] : hi_adj > 6'd15;
    dec_res = {hi_adj[3:0], lo_adj[3:0]};
  end
`else
  logic unused_dec;
  assign unused_dec = ^{bus.a_REG_IN, bus.b_REG_IN, bus.sum_op_IN, bus.subtract_IN};
`endif
  // Lowest to highest priority: ALU capture, clear, set, full load; bits 5/4 are hard-wired
  always_comb begin
    p_alu = p;
    p_alu[7] = capture & bus.flag_MASK_IN[3] ? bus.negative_FLAG_IN : p[7];
    p_alu[6] = capture & bus.flag_MASK_IN[2] ? bus.overflow_FLAG_IN : p[6];
    p_alu[1] = capture & bus.flag_MASK_IN[1] ? bus.zero_FLAG_IN : p[1];
    p_alu[0] = capture & bus.flag_MASK_IN[0] ? bus.carry_FLAG_IN : p[0];
`ifdef DECIMAL_MODE_EN
    p_alu[0] = state == DECADJ & dmask_c ? dec_c : p_alu[0];
`endif
    p_next = bus.p_LOAD_IN ? bus.p_DATA_IN : (p_alu & ~bus.flag_CLR_IN) | bus.flag_SET_IN;
    p_next[5] = 1'b1;
    p_next[4] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= EMPTY;
      hold <= HOLD_RESET_VALUE;
      valid <= 1'b0;
      p <= P_RESET_VALUE;
`ifdef DECIMAL_MODE_EN
      da <= 8'h00;
      db <= 8'h00;
      dcin <= 1'b0;
      dsub <= 1'b0;
      dmask_c <= 1'b0;
`endif
    end else begin
      p <= p_next;
      if (capture) begin
        hold <= bus.alu_result_IN;
`ifdef DECIMAL_MODE_EN
        state <= dec_go ? DECADJ : FULL;
        valid <= !dec_go;
        da <= bus.a_REG_IN;
        db <= bus.b_REG_IN;
        dcin <= p[0];
        dsub <= bus.subtract_IN;
        dmask_c <= bus.flag_MASK_IN[0];
`else
        state <= FULL;
        valid <= 1'b1;
`endif
      end else if (state == FULL && bus.hold_READY_IN) begin
        state <= EMPTY;
        valid <= 1'b0;
      end
`ifdef DECIMAL_MODE_EN
      else if (state == DECADJ) begin
        hold <= dec_res;
        state <= FULL;
        valid <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed scoreboard bench for alu_result_stage
module tb_alu_result_stage;
  logic clk, reset_N;
  int vectors = 0, errors = 0, n;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  alu_result_stage_if bus();
  alu_result_stage dut (.clk(clk), .reset_N(reset_N), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (reset_N && bus.hold_VALID_OUT && bus.hold_READY_IN) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", bus.hold_REG_OUT);
      end else begin
        exp_b = sb.pop_front();
        assert (bus.hold_REG_OUT === exp_b) else begin
          errors++;
          $error("FAIL sb_data observed=%0h expected=%0h", bus.hold_REG_OUT, exp_b);
        end
      end
    end
  end
  initial begin
    bus.alu_result_IN = 8'h00;
    bus.negative_FLAG_IN = 1'b0;
    bus.overflow_FLAG_IN = 1'b0;
    bus.zero_FLAG_IN = 1'b0;
    bus.carry_FLAG_IN = 1'b0;
    bus.a_REG_IN = 8'h00;
    bus.b_REG_IN = 8'h00;
    bus.sum_op_IN = 1'b0;
    bus.subtract_IN = 1'b0;
    bus.flag_MASK_IN = 4'h0;
    bus.result_VALID_IN = 1'b0;
    bus.hold_READY_IN = 1'b0;
    bus.p_LOAD_IN = 1'b0;
    bus.p_DATA_IN = 8'h00;
    bus.flag_SET_IN = 8'h00;
    bus.flag_CLR_IN = 8'h00;
    reset_N = 1'b0;
    tick();
    chk("rst_ready", bus.result_READY_OUT, 1'b0);
    chk("rst_valid", bus.hold_VALID_OUT, 1'b0);
    chk("rst_p", bus.p_REG_OUT, 8'h24);
    chk("rst_hold", bus.hold_REG_OUT, 8'h00);
    reset_N = 1'b1;
    bus.alu_result_IN = 8'h80;
    bus.negative_FLAG_IN = 1'b1;
    bus.overflow_FLAG_IN = 1'b1;
    bus.carry_FLAG_IN = 1'b1;
    bus.flag_MASK_IN = 4'b1011;
    bus.result_VALID_IN = 1'b1;
    sb.push_back(8'h80);
    @(negedge clk);
    chk("cap_ready", bus.result_READY_OUT, 1'b1);
    tick();
    bus.result_VALID_IN = 1'b0;
    chk("cap_hold", bus.hold_REG_OUT, 8'h80);
    chk("cap_valid", bus.hold_VALID_OUT, 1'b1);
    chk("cap_p", bus.p_REG_OUT, 8'hA5);
    bus.alu_result_IN = 8'h33;
    bus.flag_MASK_IN = 4'b0000;
    bus.result_VALID_IN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", bus.result_READY_OUT, 1'b0);
      tick();
      chk("bp_hold", bus.hold_REG_OUT, 8'h80);
      chk("bp_valid", bus.hold_VALID_OUT, 1'b1);
    end
    bus.hold_READY_IN = 1'b1;
    sb.push_back(8'h33);
    @(negedge clk);
    chk("swap_ready", bus.result_READY_OUT, 1'b1);
    tick();
    bus.result_VALID_IN = 1'b0;
    chk("swap_hold", bus.hold_REG_OUT, 8'h33);
    chk("swap_valid", bus.hold_VALID_OUT, 1'b1);
    tick();
    chk("drain_valid", bus.hold_VALID_OUT, 1'b0);
    bus.hold_READY_IN = 1'b0;
    bus.p_LOAD_IN = 1'b1;
    bus.p_DATA_IN = 8'hFF;
    bus.flag_CLR_IN = 8'h01;
    bus.alu_result_IN = 8'h5A;
    bus.negative_FLAG_IN = 1'b0;
    bus.overflow_FLAG_IN = 1'b0;
    bus.carry_FLAG_IN = 1'b0;
    bus.flag_MASK_IN = 4'b0001;
    bus.result_VALID_IN = 1'b1;
    sb.push_back(8'h5A);
    tick();
    bus.p_LOAD_IN = 1'b0;
    bus.result_VALID_IN = 1'b0;
    bus.flag_MASK_IN = 4'b0000;
    chk("prio_p", bus.p_REG_OUT, 8'hEF);
    chk("prio_hold", bus.hold_REG_OUT, 8'h5A);
    bus.hold_READY_IN = 1'b1;
    tick();
    chk("clr_c_p", bus.p_REG_OUT, 8'hEE);
    chk("prio_drain", bus.hold_VALID_OUT, 1'b0);
    bus.flag_SET_IN = 8'h01;
    tick();
    chk("setclr_p", bus.p_REG_OUT, 8'hEF);
    bus.flag_SET_IN = 8'h00;
    bus.flag_CLR_IN = 8'h40;
    tick();
    chk("clr_v_p", bus.p_REG_OUT, 8'hAF);
    bus.flag_CLR_IN = 8'h00;
    bus.p_LOAD_IN = 1'b1;
    bus.p_DATA_IN = 8'h10;
    tick();
    chk("load_fixed_bits", bus.p_REG_OUT, 8'h20);
    bus.p_LOAD_IN = 1'b0;
    bus.flag_SET_IN = 8'h08;
    bus.flag_CLR_IN = 8'h01;
    tick();
    bus.flag_SET_IN = 8'h00;
    bus.flag_CLR_IN = 8'h00;
    chk("sed_p", bus.p_REG_OUT, 8'h28);
`ifdef DECIMAL_MODE_EN
    bus.sum_op_IN = 1'b1;
    bus.a_REG_IN = 8'h19;
    bus.b_REG_IN = 8'h28;
    bus.alu_result_IN = 8'h41;
    bus.flag_MASK_IN = 4'b0001;
    bus.result_VALID_IN = 1'b1;
    sb.push_back(8'h47);
    tick();
    bus.result_VALID_IN = 1'b0;
    bus.sum_op_IN = 1'b0;
    chk("adc_pending", bus.hold_VALID_OUT, 1'b0);
    n = 1;
    while (!bus.hold_VALID_OUT && n < 4) begin
      tick();
      n++;
    end
    chk("adc_latency", n, 2);
    chk("adc_hold", bus.hold_REG_OUT, 8'h47);
    chk("adc_p", bus.p_REG_OUT, 8'h28);
    bus.flag_SET_IN = 8'h01;
    tick();
    bus.flag_SET_IN = 8'h00;
    bus.sum_op_IN = 1'b1;
    bus.subtract_IN = 1'b1;
    bus.a_REG_IN = 8'h10;
    bus.b_REG_IN = 8'hFE;
    bus.alu_result_IN = 8'h0F;
    bus.carry_FLAG_IN = 1'b1;
    bus.result_VALID_IN = 1'b1;
    sb.push_back(8'h09);
    tick();
    bus.result_VALID_IN = 1'b0;
    bus.sum_op_IN = 1'b0;
    bus.subtract_IN = 1'b0;
    bus.flag_MASK_IN = 4'b0000;
    n = 1;
    while (!bus.hold_VALID_OUT && n < 4) begin
      tick();
      n++;
    end
    chk("sbc_latency", n, 2);
    chk("sbc_hold", bus.hold_REG_OUT, 8'h09);
    chk("sbc_p", bus.p_REG_OUT, 8'h29);
    tick();
`else
    bus.sum_op_IN = 1'b1;
    bus.alu_result_IN = 8'h41;
    bus.result_VALID_IN = 1'b1;
    sb.push_back(8'h41);
    tick();
    bus.result_VALID_IN = 1'b0;
    bus.sum_op_IN = 1'b0;
    chk("bin_valid", bus.hold_VALID_OUT, 1'b1);
    chk("bin_hold", bus.hold_REG_OUT, 8'h41);
    tick();
`endif
    chk("sb_empty", sb.size(), 0);
    bus.hold_READY_IN = 1'b0;
    bus.alu_result_IN = 8'hC3;
    bus.result_VALID_IN = 1'b1;
    tick();
    bus.result_VALID_IN = 1'b0;
    chk("full_valid", bus.hold_VALID_OUT, 1'b1);
    #2 reset_N = 1'b0;
    #1;
    chk("arst_valid", bus.hold_VALID_OUT, 1'b0);
    chk("arst_p", bus.p_REG_OUT, 8'h24);
    chk("arst_hold", bus.hold_REG_OUT, 8'h00);
    chk("arst_ready", bus.result_READY_OUT, 1'b0);
    sb.delete();
    #10 reset_N = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
